lsu_arbiter: RTL and testbench

- Two-master arbiter and sequencer placed in front of the load/store unit. It shares the single LSU port between the pipeline core (master 0) and the debug/program loader (master 1).
- Round-robin arbitration with a req/gnt handshake. The granted access is registered onto the LSU port and the LSU is held for a fixed read latency.
- Completion is returned to the granted master as a one-cycle rvalid pulse carrying the captured load data.

---
 rtl/lsu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_lsu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter in front of the single LSU port.
// A granted access owns the LSU for RD_LAT cycles, then completes with an rvalid pulse.
module lsu_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wren,
  input  logic [2:0]  i_m0_type,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wren,
  input  logic [2:0]  i_m1_type,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_type_access,
  input  logic [31:0] i_ld_data
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [31:0] lsu_addr_q, lsu_addr_d;
  logic [31:0] st_data_q, st_data_d;
  logic        lsu_wren_q, lsu_wren_d;
  logic [2:0]  type_q, type_d;
  logic        m0_gnt_q, m0_gnt_d;
  logic        m1_gnt_q, m1_gnt_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        any_req_s;
  logic        winner_s;

  // Round-robin pick: on contention the master that did not win last time goes first.
  always_comb begin
    any_req_s = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      winner_s = ~last_q;
    end else if (i_m1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state and next-output computation for the grant/access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    lsu_addr_d  = lsu_addr_q;
    st_data_d   = st_data_q;
    type_d      = type_q;
    lsu_wren_d  = 1'b0;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          last_d  = winner_s;
          owner_d = winner_s;
          if (winner_s) begin
            lsu_addr_d = i_m1_addr;
            st_data_d  = i_m1_wdata;
            type_d     = i_m1_type;
            wr_d       = i_m1_wren;
            lsu_wren_d = i_m1_wren;
            m1_gnt_d   = 1'b1;
          end else begin
            lsu_addr_d = i_m0_addr;
            st_data_d  = i_m0_wdata;
            type_d     = i_m0_type;
            wr_d       = i_m0_wren;
            lsu_wren_d = i_m0_wren;
            m0_gnt_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          // Load data is only meaningful on the last access cycle, and only for reads.
          if (owner_q) begin
            m1_rvalid_d = 1'b1;
            if (!wr_q) begin
              m1_rdata_d = i_ld_data;
            end else begin
              m1_rdata_d = m1_rdata_q;
            end
          end else begin
            m0_rvalid_d = 1'b1;
            if (!wr_q) begin
              m0_rdata_d = i_ld_data;
            end else begin
              m0_rdata_d = m0_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      lsu_addr_q  <= 32'd0;
      st_data_q   <= 32'd0;
      lsu_wren_q  <= 1'b0;
      type_q      <= 3'd0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      lsu_addr_q  <= lsu_addr_d;
      st_data_q   <= st_data_d;
      lsu_wren_q  <= lsu_wren_d;
      type_q      <= type_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign o_lsu_addr    = lsu_addr_q;
  assign o_st_data     = st_data_q;
  assign o_lsu_wren    = lsu_wren_q;
  assign o_type_access = type_q;
  assign o_m0_gnt      = m0_gnt_q;
  assign o_m1_gnt      = m1_gnt_q;
  assign o_m0_rvalid   = m0_rvalid_q;
  assign o_m1_rvalid   = m1_rvalid_q;
  assign o_m0_rdata    = m0_rdata_q;
  assign o_m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: instance 0 runs RD_LAT=1, instance 1 runs RD_LAT=3.
// A transaction-level model predicts every output each cycle; directed steps pin the model.
module tb_lsu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req   [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        wren  [2][2];
  logic [2:0]  typ   [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [31:0] rdata [2][2];
  logic [31:0] lsu_addr [2];
  logic [31:0] st_data  [2];
  logic        lsu_wren [2];
  logic [2:0]  type_acc [2];
  logic [31:0] ld_data  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      lsu_arbiter #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_m0_req(req[g][0]), .i_m0_addr(addr[g][0]), .i_m0_wdata(wdata[g][0]),
        .i_m0_wren(wren[g][0]), .i_m0_type(typ[g][0]),
        .o_m0_gnt(gnt[g][0]), .o_m0_rvalid(rvalid[g][0]), .o_m0_rdata(rdata[g][0]),
        .i_m1_req(req[g][1]), .i_m1_addr(addr[g][1]), .i_m1_wdata(wdata[g][1]),
        .i_m1_wren(wren[g][1]), .i_m1_type(typ[g][1]),
        .o_m1_gnt(gnt[g][1]), .o_m1_rvalid(rvalid[g][1]), .o_m1_rdata(rdata[g][1]),
        .o_lsu_addr(lsu_addr[g]), .o_st_data(st_data[g]), .o_lsu_wren(lsu_wren[g]),
        .o_type_access(type_acc[g]), .i_ld_data(ld_data[g])
      );
    end
  endgenerate

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic pick(logic r0, logic r1, logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  // Model: a transaction granted at edge s shows gnt in cycle s, rvalid in cycle s+L,
  // and the next grant may happen at edge s+L+1.
  int          cyc = 0;
  logic        m_has [2];
  int          m_s   [2];
  logic        m_own [2];
  logic        m_last[2];
  logic        m_wr  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [2:0]  m_typ [2];
  logic [31:0] m_rd  [2][2];

  always @(posedge clk or negedge rst_n) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_has[i] <= 1'b0; m_s[i] <= 0; m_own[i] <= 1'b0; m_last[i] <= 1'b1;
        m_wr[i] <= 1'b0; m_addr[i] <= 32'd0; m_wd[i] <= 32'd0; m_typ[i] <= 3'd0;
        m_rd[i][0] <= 32'd0; m_rd[i][1] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_has[i] && (cyc + 1 == m_s[i] + lat_of(i)) && !m_wr[i])
          m_rd[i][m_own[i]] <= ld_data[i];
        if ((!m_has[i] || (cyc + 1 >= m_s[i] + lat_of(i) + 1)) && (req[i][0] || req[i][1])) begin
          m_has[i]  <= 1'b1;
          m_s[i]    <= cyc + 1;
          m_own[i]  <= pick(req[i][0], req[i][1], m_last[i]);
          m_last[i] <= pick(req[i][0], req[i][1], m_last[i]);
          m_addr[i] <= addr[i][pick(req[i][0], req[i][1], m_last[i])];
          m_wd[i]   <= wdata[i][pick(req[i][0], req[i][1], m_last[i])];
          m_wr[i]   <= wren[i][pick(req[i][0], req[i][1], m_last[i])];
          m_typ[i]  <= typ[i][pick(req[i][0], req[i][1], m_last[i])];
        end
      end
    end
  end

  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic at_g, at_r;
      at_g = m_has[i] && (cyc == m_s[i]);
      at_r = m_has[i] && (cyc == m_s[i] + lat_of(i));
      check("gnt0",    i, 32'(gnt[i][0]),    32'(at_g && !m_own[i]));
      check("gnt1",    i, 32'(gnt[i][1]),    32'(at_g && m_own[i]));
      check("rvalid0", i, 32'(rvalid[i][0]), 32'(at_r && !m_own[i]));
      check("rvalid1", i, 32'(rvalid[i][1]), 32'(at_r && m_own[i]));
      check("rdata0",  i, rdata[i][0], m_rd[i][0]);
      check("rdata1",  i, rdata[i][1], m_rd[i][1]);
      check("lsu_wren", i, 32'(lsu_wren[i]), 32'(at_g && m_wr[i]));
      check("lsu_addr", i, lsu_addr[i], m_addr[i]);
      check("st_data",  i, st_data[i], m_wd[i]);
      check("type",     i, 32'(type_acc[i]), 32'(m_typ[i]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(int i, int m, logic [31:0] a, logic [31:0] d, logic w, logic [2:0] t);
    req[i][m] = 1'b1; addr[i][m] = a; wdata[i][m] = d; wren[i][m] = w; typ[i][m] = t;
  endtask

  task automatic new_rand_req(int i, int m);
    logic [2:0] t;
    case ($urandom_range(4))
      0: t = 3'b000;
      1: t = 3'b001;
      2: t = 3'b010;
      3: t = 3'b100;
      default: t = 3'b101;
    endcase
    set_req(i, m, $urandom, $urandom, 1'($urandom_range(1)), t);
  endtask

  logic pend [2][2];

  initial begin
    int ngnt;
    logic [5:0] order;
    for (int i = 0; i < 2; i++) begin
      ld_data[i] = 32'd0;
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; addr[i][m] = 32'd0; wdata[i][m] = 32'd0;
        wren[i][m] = 1'b0; typ[i][m] = 3'd0; pend[i][m] = 1'b0;
      end
    end
    step(); step();
    check("rst_addr", 0, lsu_addr[0], 32'd0);
    check("rst_rdata0", 1, rdata[1][0], 32'd0);
    rst_n = 1'b1;

    // RD_LAT=1 read by m0
    set_req(0, 0, 32'h0000_0010, 32'd0, 1'b0, 3'b010);
    step();
    check("t1_gnt0", 0, 32'(gnt[0][0]), 32'd1);
    check("t1_wren", 0, 32'(lsu_wren[0]), 32'd0);
    check("t1_addr", 0, lsu_addr[0], 32'h0000_0010);
    req[0][0] = 1'b0; ld_data[0] = 32'hDEAD_BEEF;
    step();
    check("t1_rvalid0", 0, 32'(rvalid[0][0]), 32'd1);
    check("t1_rdata0", 0, rdata[0][0], 32'hDEAD_BEEF);
    check("t1_rdata1", 0, rdata[0][1], 32'd0);

    // RD_LAT=1 write by m1
    set_req(0, 1, 32'h1000_0000, 32'h0000_00FF, 1'b1, 3'b000);
    step();
    check("t2_gnt1", 0, 32'(gnt[0][1]), 32'd1);
    check("t2_wren", 0, 32'(lsu_wren[0]), 32'd1);
    check("t2_st", 0, st_data[0], 32'h0000_00FF);
    req[0][1] = 1'b0;
    step();
    check("t2_rvalid1", 0, 32'(rvalid[0][1]), 32'd1);
    check("t2_wren_off", 0, 32'(lsu_wren[0]), 32'd0);
    check("t2_rdata1", 0, rdata[0][1], 32'd0);

    // Continuous contention: grants alternate starting with m0
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    ngnt = 0; order = 6'd0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (gnt[0][0] || gnt[0][1]) begin
        if (ngnt < 6) order[ngnt] = gnt[0][1];
        ngnt++;
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    check("t3_ngnt", 0, 32'(ngnt), 32'd6);
    check("t3_order", 0, 32'(order), 32'b101010);

    // RD_LAT=3 read by m0, m1 requests during the access
    set_req(1, 0, 32'h0000_0020, 32'd0, 1'b0, 3'b010);
    step();
    check("t4_gnt0", 1, 32'(gnt[1][0]), 32'd1);
    req[1][0] = 1'b0; ld_data[1] = 32'h1;
    set_req(1, 1, 32'h0000_0030, 32'd0, 1'b0, 3'b100);
    step();
    ld_data[1] = 32'h2;
    check("t4_addr", 1, lsu_addr[1], 32'h0000_0020);
    step();
    ld_data[1] = 32'h3;
    check("t5_nogrant", 1, 32'(gnt[1][1]), 32'd0);
    step();
    check("t4_rvalid0", 1, 32'(rvalid[1][0]), 32'd1);
    check("t4_rdata0", 1, rdata[1][0], 32'h3);
    check("t5_nogrant2", 1, 32'(gnt[1][1]), 32'd0);
    step();
    check("t5_gnt1", 1, 32'(gnt[1][1]), 32'd1);
    req[1][1] = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // RD_LAT=3 write abandoned by reset in its second access cycle
    set_req(1, 0, 32'h0000_0040, 32'h0000_0055, 1'b1, 3'b010);
    step();
    check("t6_wren", 1, 32'(lsu_wren[1]), 32'd1);
    req[1][0] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_wren", 1, 32'(lsu_wren[1]), 32'd0);
    check("t6_rst_rdata0", 1, rdata[1][0], 32'd0);
    check("t6_rst_addr", 1, lsu_addr[1], 32'd0);
    step(); step();
    check("t6_no_rvalid", 1, 32'(rvalid[1][0]), 32'd0);
    rst_n = 1'b1;
    req[1][0] = 1'b1; req[1][1] = 1'b1;
    step();
    check("t6_gnt0", 1, 32'(gnt[1][0]), 32'd1);
    req[1][0] = 1'b0; req[1][1] = 1'b0;
    for (int k = 0; k < 5; k++) step();

    // Randomized masters: hold until gnt, occasional withdrawal and reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        ld_data[i] = $urandom;
        for (int m = 0; m < 2; m++) begin
          if (pend[i][m]) begin
            if (gnt[i][m]) begin
              pend[i][m] = 1'b0; req[i][m] = 1'b0;
              if ($urandom_range(3) == 0) begin
                new_rand_req(i, m); pend[i][m] = 1'b1;
              end
            end else if ($urandom_range(15) == 0) begin
              pend[i][m] = 1'b0; req[i][m] = 1'b0;
            end
          end else if ($urandom_range(2) == 0) begin
            new_rand_req(i, m); pend[i][m] = 1'b1;
          end
        end
      end
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
